// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
//   fetch_state_t : fetch control state (FS_RUN issues, FS_DRAIN discards stale responses)
//   cnt_width()   : width of a counter that can hold 0..depth inclusive
//   CNT_W         : counter width for the default prefetch depth
package fetch_pkg;

    typedef enum logic [0:0] {
        FS_RUN   = 1'b0,
        FS_DRAIN = 1'b1
    } fetch_state_t;

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int unsigned DEF_DEPTH = 4;
    localparam int unsigned CNT_W     = cnt_width(DEF_DEPTH);

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with synchronous clear.
//   clk, rst_n : clock, async active-low reset (storage and pointers zeroed)
//   push, din  : write din when not full
//   pop        : drop head entry when not empty
//   clear      : empty the FIFO at the next edge (overrides push/pop)
//   dout       : head entry (registered storage, valid when !empty)
//   full, empty, count : occupancy status
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = cnt_width(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues PC addresses to instruction memory, buffers
// in-order responses with their PC, and hands {instr, pc} to decode. A flush
// empties the buffers and discards responses still in flight.
//   clk, rst_n                     : clock, async active-low reset
//   pc_in, pc_valid, pc_ready      : fetch address stream from PC
//   flush                          : redirect, kills buffered and in-flight fetches
//   imem_req_valid/ready/addr      : request channel to instruction memory
//   imem_rsp_valid, imem_rsp_data  : in-order response channel
//   instr_valid/ready, instr_out, instr_pc : instruction channel to decode
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned N     = 32,
    parameter int unsigned IW    = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  pc_in,
    input  logic          pc_valid,
    output logic          pc_ready,
    input  logic          flush,
    output logic          imem_req_valid,
    input  logic          imem_req_ready,
    output logic [N-1:0]  imem_req_addr,
    input  logic          imem_rsp_valid,
    input  logic [IW-1:0] imem_rsp_data,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic [IW-1:0] instr_out,
    output logic [N-1:0]  instr_pc
);

    localparam int unsigned CW = cnt_width(DEPTH);
    localparam int unsigned BW = IW + N;

    fetch_state_t  state;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] out_after_rsp;
    logic [CW-1:0] in_use;
    logic [CW-1:0] tag_count;
    logic [CW-1:0] buf_count;
    logic [N-1:0]  tag_head;
    logic [BW-1:0] buf_head;
    logic          tag_full;
    logic          tag_empty;
    logic          buf_full;
    logic          buf_empty;
    logic          issue_ok;
    logic          req_hs;
    logic          rsp_ok;
    logic          rsp_run;
    logic          dec_hs;

    // Credit: every slot is either buffered or reserved by an in-flight request.
    assign in_use   = buf_count + outstanding;
    assign issue_ok = rst_n && (state == FS_RUN) && !flush &&
                      (in_use < CW'(DEPTH)) && !tag_full && !buf_full;

    assign imem_req_valid = pc_valid && issue_ok;
    assign pc_ready       = imem_req_ready && issue_ok;
    assign imem_req_addr  = pc_in;
    assign req_hs         = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is ignored so counters never underflow.
    assign rsp_ok        = imem_rsp_valid && (outstanding != '0);
    assign rsp_run       = rsp_ok && (state == FS_RUN) && !tag_empty;
    assign out_after_rsp = outstanding - CW'(rsp_ok);

    assign instr_valid            = !buf_empty;
    assign dec_hs                 = instr_valid && instr_ready;
    assign {instr_out, instr_pc}  = buf_head;

    // PC tags of requests in flight, oldest first.
    fetch_fifo #(.W(N), .DEPTH(DEPTH)) u_tag_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (req_hs),
        .pop   (rsp_run),
        .clear (flush),
        .din   (pc_in),
        .dout  (tag_head),
        .full  (tag_full),
        .empty (tag_empty),
        .count (tag_count)
    );

    // Prefetch buffer of {instr, pc}; flush wins over a same-cycle response.
    fetch_fifo #(.W(BW), .DEPTH(DEPTH)) u_prefetch_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rsp_run && !flush),
        .pop   (dec_hs),
        .clear (flush),
        .din   ({imem_rsp_data, tag_head}),
        .dout  (buf_head),
        .full  (buf_full),
        .empty (buf_empty),
        .count (buf_count)
    );

    // Control FSM with outstanding and stale-response counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FS_RUN;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            case (state)
                FS_RUN: begin
                    if (flush) begin
                        // Everything still in flight after this cycle is stale.
                        outstanding <= out_after_rsp;
                        drop_cnt    <= out_after_rsp;
                        state       <= (out_after_rsp == '0) ? FS_RUN : FS_DRAIN;
                    end else begin
                        outstanding <= outstanding + CW'(req_hs) - CW'(rsp_ok);
                    end
                end
                FS_DRAIN: begin
                    if (rsp_ok) begin
                        outstanding <= out_after_rsp;
                        if (drop_cnt != '0) begin
                            drop_cnt <= drop_cnt - CW'(1);
                        end
                        if (drop_cnt <= CW'(1)) begin
                            state <= FS_RUN;
                        end
                    end
                end
                default: state <= FS_RUN;
            endcase
        end
    end

    // Memory must not respond with no request outstanding.
    a_rsp_has_req: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rsp_valid |-> (outstanding != '0));

    // While running, every outstanding request has exactly one tag.
    a_tag_tracks_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
        (state == FS_RUN) |-> (tag_count == outstanding));

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    localparam int unsigned N     = 32;
    localparam int unsigned IW    = 32;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  pc_in;
    logic          pc_valid;
    logic          pc_ready;
    logic          flush;
    logic          imem_req_valid;
    logic          imem_req_ready;
    logic [N-1:0]  imem_req_addr;
    logic          imem_rsp_valid;
    logic [IW-1:0] imem_rsp_data;
    logic          instr_valid;
    logic          instr_ready;
    logic [IW-1:0] instr_out;
    logic [N-1:0]  instr_pc;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.N(N), .IW(IW), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc_in          (pc_in),
        .pc_valid       (pc_valid),
        .pc_ready       (pc_ready),
        .flush          (flush),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_out      (instr_out),
        .instr_pc       (instr_pc)
    );

    // Edge counter: at a falling edge it holds the number of rising edges so far.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [IW-1:0] instr_of(input logic [N-1:0] a);
        return 32'hC0DE_0000 | {16'h0000, a[15:0]};
    endfunction

    // In-order memory model; mem_lat=L answers in the cycle ending L edges after accept.
    typedef struct {
        logic [N-1:0] addr;
        int           due;
    } mreq_t;
    mreq_t mem_q[$];
    int    mem_lat = 1;

    always @(negedge clk) begin
        if (rst_n && imem_req_valid && imem_req_ready)
            mem_q.push_back('{addr: imem_req_addr, due: cyc + 1 + mem_lat});
    end

    always @(posedge clk) begin
        #1;
        imem_rsp_valid = 1'b0;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc + 1) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = instr_of(mem_q[0].addr);
            void'(mem_q.pop_front());
        end
    end

    // Observation log, sampled on the falling edge.
    int           acc_cnt, first_acc_cyc, last_acc_cyc;
    int           rsp_cnt, last_rsp_cyc;
    int           first_valid_cyc;
    bit           valid_seen;
    logic [N-1:0] got_pc[$];
    logic [IW-1:0] got_instr[$];

    always @(negedge clk) begin
        if (pc_valid && pc_ready) begin
            acc_cnt++;
            last_acc_cyc = cyc;
            if (first_acc_cyc < 0) first_acc_cyc = cyc;
        end
        if (imem_rsp_valid) begin
            rsp_cnt++;
            last_rsp_cyc = cyc;
        end
        if (instr_valid) begin
            valid_seen = 1'b1;
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
        end
        if (instr_valid && instr_ready) begin
            got_pc.push_back(instr_pc);
            got_instr.push_back(instr_out);
        end
    end

    task automatic clear_logs();
        acc_cnt = 0; first_acc_cyc = -1; last_acc_cyc = -1;
        rsp_cnt = 0; last_rsp_cyc = -1;
        first_valid_cyc = -1; valid_seen = 1'b0;
        got_pc.delete(); got_instr.delete();
    endtask

    // PC source: feed_left addresses starting at pc_in, advancing on each accept.
    int feed_left = 0;

    task automatic start_feed(input logic [N-1:0] addr, input int n);
        pc_in     = addr;
        feed_left = n;
        pc_valid  = (n > 0);
    endtask

    // One clock; returns #1 after the rising edge.
    task automatic step();
        logic hs;
        @(negedge clk);
        hs = pc_valid && pc_ready;
        @(posedge clk);
        #1;
        if (hs) begin
            pc_in = pc_in + 1;
            feed_left--;
            if (feed_left <= 0) pc_valid = 1'b0;
        end
    endtask

    task automatic wait_decode(input int n, input int budget);
        int b = budget;
        while (got_pc.size() < n && b > 0) begin
            step();
            b--;
        end
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        pc_valid    = 1'b0;
        flush       = 1'b0;
        instr_ready = 1'b0;
        feed_left   = 0;
        mem_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        clear_logs();
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        pc_valid       = 1'b1;
        pc_in          = 32'h7;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        flush          = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        #3;
        tests_run++; if (pc_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_pc_ready: got %b expected 0", pc_ready); end
        tests_run++; if (imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid); end
        tests_run++; if (instr_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_instr_valid: got %b expected 0", instr_valid); end
        tests_run++; if (instr_out !== '0) begin tests_failed++; $display("FAIL reset_instr_out: got %h expected 0", instr_out); end
        tests_run++; if (instr_pc !== '0) begin tests_failed++; $display("FAIL reset_instr_pc: got %h expected 0", instr_pc); end
        pc_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++; if (pc_ready !== 1'b1) begin tests_failed++; $display("FAIL post_reset_pc_ready: got %b expected 1", pc_ready); end
        tests_run++; if (instr_valid !== 1'b0) begin tests_failed++; $display("FAIL post_reset_instr_valid: got %b expected 0", instr_valid); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_stream();
        do_reset();
        mem_lat     = 1;
        instr_ready = 1'b1;
        start_feed(32'h0, 4);
        wait_decode(4, 30);
        tests_run++; if (got_pc.size() !== 4) begin tests_failed++; $display("FAIL stream_count: got %0d expected 4", got_pc.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < got_pc.size()) begin
                tests_run++; if (got_pc[i] !== N'(i)) begin tests_failed++; $display("FAIL stream_pc[%0d]: got %h expected %h", i, got_pc[i], N'(i)); end
                tests_run++; if (got_instr[i] !== instr_of(N'(i))) begin tests_failed++; $display("FAIL stream_instr[%0d]: got %h expected %h", i, got_instr[i], instr_of(N'(i))); end
            end
        end
        tests_run++; if (first_valid_cyc - first_acc_cyc !== 2) begin tests_failed++; $display("FAIL stream_latency: got %0d expected 2", first_valid_cyc - first_acc_cyc); end
    endtask

    task automatic test_backpressure();
        do_reset();
        mem_lat     = 1;
        instr_ready = 1'b0;
        start_feed(32'h10, 100);
        repeat (10) step();
        tests_run++; if (acc_cnt !== 4) begin tests_failed++; $display("FAIL bp_accepts_full: got %0d expected 4", acc_cnt); end
        @(negedge clk);
        tests_run++; if (pc_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_pc_ready_full: got %b expected 0", pc_ready); end
        tests_run++; if (instr_pc !== 32'h10) begin tests_failed++; $display("FAIL bp_head_pc: got %h expected 10", instr_pc); end
        @(posedge clk);
        #1;
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        repeat (6) step();
        tests_run++; if (acc_cnt !== 5) begin tests_failed++; $display("FAIL bp_accepts_after_pop: got %0d expected 5", acc_cnt); end
        tests_run++; if (got_pc.size() !== 1) begin tests_failed++; $display("FAIL bp_pops: got %0d expected 1", got_pc.size()); end
        @(negedge clk);
        tests_run++; if (pc_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_pc_ready_refull: got %b expected 0", pc_ready); end
        tests_run++; if (instr_pc !== 32'h11) begin tests_failed++; $display("FAIL bp_head_after_pop: got %h expected 11", instr_pc); end
        @(posedge clk);
        #1;
        pc_valid  = 1'b0;
        feed_left = 0;
    endtask

    task automatic test_flush_drain();
        int b;
        do_reset();
        mem_lat     = 4;  // long enough that all three are still in flight at the flush
        instr_ready = 1'b1;
        start_feed(32'h20, 3);
        repeat (3) step();
        tests_run++; if (acc_cnt !== 3) begin tests_failed++; $display("FAIL drain_inflight: got %0d expected 3", acc_cnt); end
        valid_seen = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        start_feed(32'h40, 1);
        b = 20;
        while (feed_left > 0 && b > 0) begin step(); b--; end
        tests_run++; if (feed_left !== 0) begin tests_failed++; $display("FAIL drain_new_accept: got %0d pending expected 0", feed_left); end
        tests_run++; if (rsp_cnt !== 3) begin tests_failed++; $display("FAIL drain_stale_rsps: got %0d expected 3", rsp_cnt); end
        tests_run++; if (last_acc_cyc !== last_rsp_cyc + 1) begin tests_failed++; $display("FAIL drain_accept_cycle: got %0d expected %0d", last_acc_cyc, last_rsp_cyc + 1); end
        tests_run++; if (valid_seen !== 1'b0) begin tests_failed++; $display("FAIL drain_no_valid: got %b expected 0", valid_seen); end
        wait_decode(1, 20);
        tests_run++; if (got_pc.size() !== 1) begin tests_failed++; $display("FAIL drain_decoded: got %0d expected 1", got_pc.size()); end
        if (got_pc.size() > 0) begin
            tests_run++; if (got_pc[0] !== 32'h40) begin tests_failed++; $display("FAIL drain_first_pc: got %h expected 40", got_pc[0]); end
            tests_run++; if (got_instr[0] !== instr_of(32'h40)) begin tests_failed++; $display("FAIL drain_first_instr: got %h expected %h", got_instr[0], instr_of(32'h40)); end
        end
    endtask

    task automatic test_flush_with_rsp();
        int b;
        do_reset();
        mem_lat     = 3;
        instr_ready = 1'b1;
        start_feed(32'h50, 2);
        repeat (2) step();
        valid_seen = 1'b0;
        step();
        flush = 1'b1;  // response for 0x50 arrives in this same cycle
        step();
        flush = 1'b0;
        start_feed(32'h60, 1);
        b = 20;
        while (feed_left > 0 && b > 0) begin step(); b--; end
        tests_run++; if (feed_left !== 0) begin tests_failed++; $display("FAIL frsp_new_accept: got %0d pending expected 0", feed_left); end
        tests_run++; if (rsp_cnt !== 2) begin tests_failed++; $display("FAIL frsp_stale_rsps: got %0d expected 2", rsp_cnt); end
        tests_run++; if (last_acc_cyc !== last_rsp_cyc + 1) begin tests_failed++; $display("FAIL frsp_accept_cycle: got %0d expected %0d", last_acc_cyc, last_rsp_cyc + 1); end
        wait_decode(1, 20);
        tests_run++; if (valid_seen !== 1'b1 || got_pc.size() !== 1) begin tests_failed++; $display("FAIL frsp_decoded: got %0d expected 1", got_pc.size()); end
        if (got_pc.size() > 0) begin
            tests_run++; if (got_pc[0] !== 32'h60) begin tests_failed++; $display("FAIL frsp_first_pc: got %h expected 60", got_pc[0]); end
        end
    endtask

    task automatic test_flush_with_pop();
        do_reset();
        mem_lat     = 1;
        instr_ready = 1'b0;
        start_feed(32'h70, 3);
        repeat (5) step();
        @(negedge clk);
        tests_run++; if (instr_pc !== 32'h70) begin tests_failed++; $display("FAIL fpop_head_pc: got %h expected 70", instr_pc); end
        @(posedge clk);
        #1;
        flush       = 1'b1;
        instr_ready = 1'b1;
        step();
        flush = 1'b0;
        @(negedge clk);
        tests_run++; if (instr_valid !== 1'b0) begin tests_failed++; $display("FAIL fpop_emptied: got %b expected 0", instr_valid); end
        @(posedge clk);
        #1;
        tests_run++; if (got_pc.size() !== 1) begin tests_failed++; $display("FAIL fpop_consumed_once: got %0d expected 1", got_pc.size()); end
        start_feed(32'h80, 1);
        wait_decode(2, 20);
        tests_run++; if (got_pc.size() !== 2) begin tests_failed++; $display("FAIL fpop_refetch_count: got %0d expected 2", got_pc.size()); end
        if (got_pc.size() > 1) begin
            tests_run++; if (got_pc[0] !== 32'h70) begin tests_failed++; $display("FAIL fpop_popped_pc: got %h expected 70", got_pc[0]); end
            tests_run++; if (got_pc[1] !== 32'h80) begin tests_failed++; $display("FAIL fpop_next_pc: got %h expected 80", got_pc[1]); end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        mem_lat     = 1;
        instr_ready = 1'b0;
        start_feed(32'h90, 3);
        repeat (5) step();
        pc_in    = 32'h99;
        pc_valid = 1'b1;
        @(negedge clk);
        tests_run++; if (instr_valid !== 1'b1) begin tests_failed++; $display("FAIL areset_pre_valid: got %b expected 1", instr_valid); end
        #2;
        mem_q.delete();
        rst_n = 1'b0;
        #1;
        tests_run++; if (pc_ready !== 1'b0) begin tests_failed++; $display("FAIL areset_pc_ready: got %b expected 0", pc_ready); end
        tests_run++; if (imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL areset_req_valid: got %b expected 0", imem_req_valid); end
        tests_run++; if (instr_valid !== 1'b0) begin tests_failed++; $display("FAIL areset_instr_valid: got %b expected 0", instr_valid); end
        tests_run++; if (instr_out !== '0) begin tests_failed++; $display("FAIL areset_instr_out: got %h expected 0", instr_out); end
        tests_run++; if (instr_pc !== '0) begin tests_failed++; $display("FAIL areset_instr_pc: got %h expected 0", instr_pc); end
        pc_valid  = 1'b0;
        feed_left = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        clear_logs();
        instr_ready = 1'b1;
        start_feed(32'h5, 1);
        wait_decode(1, 20);
        tests_run++; if (got_pc.size() !== 1) begin tests_failed++; $display("FAIL areset_refetch_count: got %0d expected 1", got_pc.size()); end
        if (got_pc.size() > 0) begin
            tests_run++; if (got_pc[0] !== 32'h5) begin tests_failed++; $display("FAIL areset_refetch_pc: got %h expected 5", got_pc[0]); end
            tests_run++; if (got_instr[0] !== instr_of(32'h5)) begin tests_failed++; $display("FAIL areset_refetch_instr: got %h expected %h", got_instr[0], instr_of(32'h5)); end
        end
    endtask

    initial begin
        clear_logs();
        test_reset();
        test_stream();
        test_backpressure();
        test_flush_drain();
        test_flush_with_rsp();
        test_flush_with_pop();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
